gsu_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the GSU execution core.
- Accepts an opcode fetch request (PBR:PC) from the core.
- Serves the byte from the 512-byte code cache when the address is inside the CBR window and the line is valid.
- Otherwise fills the 16-byte line from the ROM/RAM bus, or fetches directly when the address is outside the window. Owns the cache valid flags and the cache write port.

---
 rtl/gsu_fetch.sv | 139 +++++++++++++
 tb/tb_gsu_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gsu_fetch.sv
// gsu_fetch: GSU opcode fetch stage; serves bytes from the 512-byte code cache,
// fills 16-byte lines from the bus on a window miss, or fetches directly outside the window.
module gsu_fetch #(
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 32
) (
  input  logic                 clkin,
  input  logic                 RESET,
  input  logic                 fetch_req,
  input  logic [15:0]          fetch_pc,
  input  logic [7:0]           pbr,
  input  logic [15:0]          cbr,
  input  logic                 cache_clear,
  output logic                 fetch_rdy,
  output logic                 op_valid,
  output logic [7:0]           op_data,
  output logic                 mem_req,
  output logic [23:0]          mem_addr,
  input  logic                 mem_rdy,
  input  logic [7:0]           mem_data,
  output logic [8:0]           cache_addr,
  output logic                 cache_we,
  output logic [7:0]           cache_din,
  input  logic [7:0]           cache_dout,
  output logic [NUM_LINES-1:0] cache_flags
);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int NW = $clog2(NUM_LINES);
  localparam int DW = LW + NW;
  typedef enum logic [2:0] {S_IDLE, S_HIT, S_FILL_REQ, S_FILL_WR, S_DIRECT} state_t;
  state_t                 r_state;
  logic [NUM_LINES-1:0]   r_flags;
  logic                   r_mem_req;
  logic [23:0]            r_mem_addr;
  logic                   r_cache_we;
  logic [DW-1:0]          r_cache_addr;
  logic [7:0]             r_cache_din;
  logic                   r_op_valid;
  logic [7:0]             r_op_data;
  logic [NW-1:0]          r_line;
  logic [LW-1:0]          r_idx;
  logic [LW-1:0]          r_k;
  logic [7:0]             r_hold;
  logic                   r_poison;
  logic [15:0]            w_off;
  logic                   w_in_win;
  assign w_off       = fetch_pc - (cbr & 16'hFFF0);
  assign w_in_win    = w_off < 16'(LINE_BYTES * NUM_LINES);
  assign fetch_rdy   = r_state == S_IDLE;
  assign op_valid    = r_op_valid;
  assign op_data     = r_op_data;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign cache_we    = r_cache_we;
  assign cache_din   = r_cache_din;
  assign cache_flags = r_flags;
  // A hit must present its address in the accept cycle to meet the 2-cycle latency.
  assign cache_addr  = (r_state == S_IDLE && fetch_req) ? w_off[DW-1:0] : r_cache_addr;
  always_ff @(posedge clkin) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_flags      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_cache_we   <= 1'b0;
      r_cache_addr <= '0;
      r_cache_din  <= '0;
      r_op_valid   <= 1'b0;
      r_op_data    <= '0;
      r_line       <= '0;
      r_idx        <= '0;
      r_k          <= '0;
      r_hold       <= '0;
      r_poison     <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      r_cache_we <= 1'b0;
      if (cache_clear) r_flags <= '0;
      case (r_state)
        S_IDLE: if (fetch_req) begin
          r_line       <= w_off[DW-1:LW];
          r_idx        <= w_off[LW-1:0];
          r_k          <= '0;
          r_poison     <= cache_clear;
          r_cache_addr <= w_off[DW-1:0];
          if (!w_in_win) begin
            r_state    <= S_DIRECT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {pbr, fetch_pc};
          end else if (r_flags[w_off[DW-1:LW]]) begin
            r_state <= S_HIT;
          end else begin
            r_state    <= S_FILL_REQ;
            r_mem_req  <= 1'b1;
            r_mem_addr <= {pbr, fetch_pc[15:LW], {LW{1'b0}}};
          end
        end
        S_HIT: begin
          r_op_valid <= 1'b1;
          r_op_data  <= cache_dout;
          r_state    <= S_IDLE;
        end
        S_FILL_REQ: begin
          if (cache_clear) r_poison <= 1'b1;
          if (mem_rdy) begin
            r_mem_req    <= 1'b0;
            r_cache_we   <= 1'b1;
            r_cache_addr <= {r_line, r_k};
            r_cache_din  <= mem_data;
            if (r_k == r_idx) r_hold <= mem_data;
            r_state <= S_FILL_WR;
          end
        end
        S_FILL_WR: begin
          if (cache_clear) r_poison <= 1'b1;
          // A clear seen anywhere in the fill leaves the line invalid even though the byte is delivered.
          if (&r_k) begin
            r_op_valid <= 1'b1;
            r_op_data  <= r_hold;
            if (!r_poison && !cache_clear) r_flags[r_line] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_k                  <= r_k + 1'b1;
            r_mem_req            <= 1'b1;
            r_mem_addr[LW-1:0]   <= r_k + 1'b1;
            r_state              <= S_FILL_REQ;
          end
        end
        S_DIRECT: if (mem_rdy) begin
          r_mem_req  <= 1'b0;
          r_op_valid <= 1'b1;
          r_op_data  <= mem_data;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gsu_fetch.sv
// tb_gsu_fetch: directed and random fetches checked against a line-level model of the code cache.
module tb_gsu_fetch;
  logic        clkin;
  logic        RESET;
  logic        fetch_req;
  logic [15:0] fetch_pc;
  logic [7:0]  pbr;
  logic [15:0] cbr;
  logic        cache_clear;
  logic        fetch_rdy;
  logic        op_valid;
  logic [7:0]  op_data;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_rdy;
  logic [7:0]  mem_data;
  logic [8:0]  cache_addr;
  logic        cache_we;
  logic [7:0]  cache_din;
  logic [7:0]  cache_dout;
  logic [31:0] cache_flags;

  gsu_fetch dut (
    .clkin(clkin), .RESET(RESET), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .pbr(pbr),
    .cbr(cbr), .cache_clear(cache_clear), .fetch_rdy(fetch_rdy), .op_valid(op_valid),
    .op_data(op_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .cache_addr(cache_addr), .cache_we(cache_we), .cache_din(cache_din),
    .cache_dout(cache_dout), .cache_flags(cache_flags)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  logic [7:0] cram [512];
  always @(posedge clkin) begin
    if (cache_we) cram[cache_addr] <= cache_din;
    cache_dout <= cram[cache_addr];
  end

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wait_cnt = 0;
  int          hold_at = -1;
  logic        bus_en = 1'b1;
  logic [7:0]  salt;
  logic [31:0] mflags;
  logic [7:0]  cdata [512];
  int          acc_q [$];
  int          ov_q [$];
  logic [7:0]  ovd_q [$];
  logic [23:0] rd_q [$];
  logic [16:0] wr_q [$];

  function automatic logic [7:0] bus_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {a[3:0], a[7:4]} ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete(); ov_q.delete(); ovd_q.delete(); rd_q.delete(); wr_q.delete();
  endtask

  // One clock: note an accept, step, sample outputs, then play the bus responder.
  task automatic tick();
    if (fetch_req && fetch_rdy) acc_q.push_back(cyc);
    @(posedge clkin); #1;
    cyc++;
    if (op_valid) begin ov_q.push_back(cyc); ovd_q.push_back(op_data); end
    if (cache_we) wr_q.push_back({cache_addr, cache_din});
    if (bus_en) begin
      mem_rdy = 1'b0;
      if (mem_req && rd_q.size() != hold_at) begin
        if (wait_cnt == 0) begin
          mem_rdy = 1'b1;
          mem_data = bus_byte(mem_addr);
          rd_q.push_back(mem_addr);
          wait_cnt = $urandom_range(0, 2);
        end else wait_cnt--;
      end
    end
  endtask

  // clr_k: -1 none, -2 with the accept, k>=0 alongside the bus response for byte k.
  task automatic do_fetch(input logic [15:0] pc, input int clr_k);
    logic [15:0] off;
    logic [15:0] base;
    logic        did_clr;
    logic        clr_sent;
    logic [7:0]  exp_d;
    logic [23:0] a;
    off = pc - (cbr & 16'hFFF0);
    base = pc & 16'hFFF0;
    clear_logs();
    fetch_pc = pc;
    fetch_req = 1'b1;
    cache_clear = (clr_k == -2);
    did_clr = cache_clear;
    clr_sent = did_clr;
    for (int i = 0; i < 400 && ov_q.size() == 0; i++) begin
      tick();
      if (acc_q.size() > 0) fetch_req = 1'b0;
      cache_clear = 1'b0;
      if (clr_k >= 0 && !clr_sent && rd_q.size() == clr_k + 1) begin
        cache_clear = 1'b1; clr_sent = 1'b1; did_clr = 1'b1;
      end
    end
    tick();
    cache_clear = 1'b0;
    tick();
    check("op_valid_count", ov_q.size(), 1);
    check("accept_count", acc_q.size(), 1);
    if (off >= 16'd512) begin
      check("direct_reads", rd_q.size(), 1);
      if (rd_q.size() > 0) check("direct_addr", rd_q[0], {pbr, pc});
      check("direct_writes", wr_q.size(), 0);
      exp_d = bus_byte({pbr, pc});
    end else if (mflags[off[8:4]]) begin
      check("hit_reads", rd_q.size(), 0);
      check("hit_writes", wr_q.size(), 0);
      if (ov_q.size() > 0 && acc_q.size() > 0) check("hit_latency", ov_q[0] - acc_q[0], 2);
      exp_d = cdata[off[8:0]];
    end else begin
      check("fill_reads", rd_q.size(), 16);
      check("fill_writes", wr_q.size(), 16);
      for (int k = 0; k < 16; k++) begin
        a = {pbr, base + 16'(k)};
        if (k < rd_q.size()) check("fill_addr", rd_q[k], a);
        if (k < wr_q.size()) check("fill_write", wr_q[k], {off[8:4], 4'(k), bus_byte(a)});
        cdata[{off[8:4], 4'(k)}] = bus_byte(a);
      end
      exp_d = bus_byte({pbr, pc});
      if (!did_clr) mflags[off[8:4]] = 1'b1;
    end
    if (did_clr) mflags = '0;
    if (ovd_q.size() > 0) check("op_data", ovd_q[0], exp_d);
    check("flags", cache_flags, mflags);
    check("fetch_rdy_after", fetch_rdy, 1);
  endtask

  initial begin
    logic found;
    int   n;
    int   r;
    int   ck;
    salt = 8'($urandom);
    mflags = '0;
    RESET = 1'b1; fetch_req = 1'b0; fetch_pc = '0; pbr = 8'h01; cbr = 16'h8000;
    cache_clear = 1'b0; mem_rdy = 1'b0; mem_data = '0;
    for (int i = 0; i < 512; i++) cram[i] = '0;
    repeat (3) tick();
    RESET = 1'b0;
    check("rst_fetch_rdy", fetch_rdy, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_data", op_data, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cache_we", cache_we, 0);
    check("rst_cache_addr", cache_addr, 0);
    check("rst_flags", cache_flags, 0);
    mem_rdy = 1'b1;
    tick();
    mem_rdy = 1'b0;
    check("idle_mem_rdy_op_valid", op_valid, 0);
    check("idle_mem_rdy_we", cache_we, 0);

    do_fetch(16'h8013, -1);
    check("cold_flags", cache_flags, 32'h0000_0002);
    if (ovd_q.size() > 0) check("cold_byte", ovd_q[0], bus_byte(24'h018013));
    do_fetch(16'h801F, -1);
    if (ovd_q.size() > 0) check("hit_byte", ovd_q[0], bus_byte(24'h01801F));
    do_fetch(16'h8200, -1);
    do_fetch(16'h7FFF, -1);
    check("oow_flags", cache_flags, 32'h0000_0002);

    do_fetch(16'h8035, 7);
    check("clear_fill_flags", cache_flags, 0);
    do_fetch(16'h8035, -1);
    check("refill_flags", cache_flags, 32'h0000_0008);
    do_fetch(16'h803A, -2);
    check("hit_clear_flags", cache_flags, 0);

    do_fetch(16'h8000, -1);
    clear_logs();
    hold_at = 5;
    fetch_pc = 16'h8045; fetch_req = 1'b1; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (acc_q.size() > 0) fetch_req = 1'b0;
      found = mem_req && rd_q.size() == 5;
    end
    check("rst_fill_reached_k5", found, 1);
    bus_en = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mflags = '0;
    check("rst_fill_mem_req", mem_req, 0);
    check("rst_fill_rdy", fetch_rdy, 1);
    check("rst_fill_flags", cache_flags, 0);
    check("rst_fill_op_valid", op_valid, 0);
    n = wr_q.size();
    mem_rdy = 1'b1; mem_data = 8'hA5;
    tick();
    mem_rdy = 1'b0;
    tick();
    check("late_rdy_op_valid", ov_q.size(), 0);
    check("late_rdy_writes", wr_q.size(), n);
    check("late_rdy_mem_req", mem_req, 0);
    check("late_rdy_fetch_rdy", fetch_rdy, 1);
    bus_en = 1'b1; hold_at = -1;

    do_fetch(16'h8000, -1);
    clear_logs();
    fetch_pc = 16'h8000; fetch_req = 1'b1; n = 0;
    for (int i = 0; i < 40 && ov_q.size() < 3; i++) begin
      tick();
      if (acc_q.size() > n) begin
        n = acc_q.size();
        if (n < 3) fetch_pc = 16'h8000 + 16'(n); else fetch_req = 1'b0;
      end
    end
    fetch_req = 1'b0;
    tick(); tick();
    check("b2b_accepts", acc_q.size(), 3);
    check("b2b_pulses", ov_q.size(), 3);
    check("b2b_reads", rd_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      if (i < ov_q.size() && i < acc_q.size()) begin
        check("b2b_latency", ov_q[i] - acc_q[i], 2);
        check("b2b_data", ovd_q[i], cdata[i]);
      end
    end

    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 0) cbr = {4'h8, 12'($urandom)};
      pbr = 8'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      ck = (r == 0) ? -2 : (r == 1) ? int'($urandom_range(0, 15)) : -1;
      do_fetch((cbr & 16'hFFF0) + 16'($urandom_range(0, 700)) - 16'd64, ck);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
